// File: rtl/citadel_uart_if.sv
// rtl/citadel_uart_if.sv - byte port between the citadel core and its UART
//
// Purpose: groups the core-facing byte handshake and status/error signals.
//   master : core side (drives tx/tx_ready/rx_ack/clr_err)
//   slave  : UART side (drives rx/rx_ready/tx_full and the sticky flags)
// Signals:
//   tx[7:0], tx_ready        byte to transmit, one-cycle push strobe
//   rx[7:0], rx_ready        received byte, level "unconsumed byte held"
//   rx_ack                   one-cycle strobe, core consumed rx
//   tx_full                  TX FIFO full
//   tx_overflow, rx_overrun, rx_frame_err   sticky error flags
//   clr_err                  clears the sticky flags
interface citadel_uart_if;
  logic [7:0] tx;
  logic       tx_ready;
  logic [7:0] rx;
  logic       rx_ready;
  logic       rx_ack;
  logic       tx_full;
  logic       tx_overflow;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       clr_err;

  modport master (
    output tx, tx_ready, rx_ack, clr_err,
    input  rx, rx_ready, tx_full, tx_overflow, rx_overrun, rx_frame_err
  );

  modport slave (
    input  tx, tx_ready, rx_ack, clr_err,
    output rx, rx_ready, tx_full, tx_overflow, rx_overrun, rx_frame_err
  );
endinterface

// File: rtl/citadel_uart.sv
// rtl/citadel_uart.sv - 8N1 UART with TX FIFO and single RX holding register
//
// Purpose: serial-line end of the citadel byte IO port. TX bytes are pushed
//   into a 2**TXF_AW deep FIFO and sent LSB first, 1 start, 8 data, 1 stop.
//   RX samples a synchronised line mid-bit and hands bytes to the core.
// Ports:
//   r_clk     system clock
//   rst       asynchronous reset, active-high
//   bus       citadel_uart_if.slave (byte handshake, full, sticky flags)
//   uart_txd  serial out, idle high
//   uart_rxd  serial in, asynchronous to r_clk
module citadel_uart #(
  parameter int CLK_DIV = 434,
  parameter int TXF_AW  = 4
) (
  input  logic           r_clk,
  input  logic           rst,
  citadel_uart_if.slave  bus,
  output logic           uart_txd,
  input  logic           uart_rxd
);
  localparam int DEPTH = 1 << TXF_AW;
  localparam int CW    = TXF_AW + 1;
  localparam int BW    = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLK_DIV - 1);
  localparam logic [BW-1:0] HALF_RELOAD = BW'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [7:0]        mem_q [DEPTH];
  logic [TXF_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d, ovf_q, ovf_d;
  state_e            tx_state_q, tx_state_d;
  logic [BW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [7:0]        tx_sh_q, tx_sh_d;
  logic              txd_q, txd_d;
  logic              push, pop;

  logic              rxs1_q, rxs2_q;
  state_e            rx_state_q, rx_state_d;
  logic [BW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic              rx_rdy_q, rx_rdy_d, armed_q, armed_d;
  logic              ovr_q, ovr_d, ferr_q, ferr_d;
  logic              deliver, stop_bad, rx_in;

  // TX FIFO and TX FSM
  always_comb begin
    push       = bus.tx_ready && !full_q;
    pop        = 1'b0;
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    case (tx_state_q)
      S_IDLE: if (count_q != '0) begin
        pop        = 1'b1;
        tx_sh_d    = mem_q[rd_ptr_q];
        tx_cnt_d   = BAUD_RELOAD;
        tx_state_d = S_START;
      end
      S_START: if (tx_cnt_q == '0) begin
        tx_cnt_d   = BAUD_RELOAD;
        tx_bit_d   = 3'd0;
        tx_state_d = S_DATA;
      end else tx_cnt_d = tx_cnt_q - 1'b1;
      S_DATA: if (tx_cnt_q == '0) begin
        tx_cnt_d = BAUD_RELOAD;
        tx_sh_d  = tx_sh_q >> 1;
        if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
        else tx_bit_d = tx_bit_q + 3'd1;
      end else tx_cnt_d = tx_cnt_q - 1'b1;
      default: if (tx_cnt_q == '0) begin
        // Chain straight into the next frame so back-to-back bytes have no gap.
        if (count_q != '0) begin
          pop        = 1'b1;
          tx_sh_d    = mem_q[rd_ptr_q];
          tx_cnt_d   = BAUD_RELOAD;
          tx_state_d = S_START;
        end else tx_state_d = S_IDLE;
      end else tx_cnt_d = tx_cnt_q - 1'b1;
    endcase
    wr_ptr_d = wr_ptr_q + TXF_AW'(push);
    rd_ptr_d = rd_ptr_q + TXF_AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    full_d   = (count_d == CW'(DEPTH));
    ovf_d    = (bus.tx_ready && full_q) || (ovf_q && !bus.clr_err);
    // txd follows the state one cycle late, so every phase keeps CLK_DIV cycles.
    case (tx_state_q)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = tx_sh_q[0];
      default: txd_d = 1'b1;
    endcase
  end

  // RX FSM and holding register
  always_comb begin
    rx_in      = rxs2_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    armed_d    = armed_q;
    deliver    = 1'b0;
    stop_bad   = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        // After a framing error, wait for an idle-high line before re-arming.
        armed_d = armed_q || rx_in;
        if (armed_q && !rx_in) begin
          rx_cnt_d   = HALF_RELOAD;
          rx_state_d = S_START;
        end
      end
      S_START: if (rx_cnt_q == '0) begin
        if (rx_in) rx_state_d = S_IDLE;
        else begin
          rx_cnt_d   = BAUD_RELOAD;
          rx_bit_d   = 3'd0;
          rx_state_d = S_DATA;
        end
      end else rx_cnt_d = rx_cnt_q - 1'b1;
      S_DATA: if (rx_cnt_q == '0) begin
        rx_sh_d  = {rx_in, rx_sh_q[7:1]};
        rx_cnt_d = BAUD_RELOAD;
        if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        else rx_bit_d = rx_bit_q + 3'd1;
      end else rx_cnt_d = rx_cnt_q - 1'b1;
      default: if (rx_cnt_q == '0) begin
        rx_state_d = S_IDLE;
        if (rx_in) deliver = 1'b1;
        else begin
          stop_bad = 1'b1;
          armed_d  = 1'b0;
        end
      end else rx_cnt_d = rx_cnt_q - 1'b1;
    endcase
    rx_data_d = rx_data_q;
    rx_rdy_d  = rx_rdy_q;
    ovr_d     = ovr_q && !bus.clr_err;
    // A same-cycle ack frees the holding register, so the new byte loads.
    if (deliver && (!rx_rdy_q || bus.rx_ack)) begin
      rx_data_d = rx_sh_q;
      rx_rdy_d  = 1'b1;
    end else if (deliver) begin
      ovr_d = 1'b1;
    end else if (bus.rx_ack) begin
      rx_rdy_d = 1'b0;
    end
    ferr_d = stop_bad || (ferr_q && !bus.clr_err);
  end

  always_ff @(posedge r_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.tx;
  end

  always_ff @(posedge r_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
      rxs1_q     <= 1'b1;
      rxs2_q     <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_rdy_q   <= 1'b0;
      armed_q    <= 1'b1;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
      rxs1_q     <= uart_rxd;
      rxs2_q     <= rxs1_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_rdy_q   <= rx_rdy_d;
      armed_q    <= armed_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign uart_txd         = txd_q;
  assign bus.rx           = rx_data_q;
  assign bus.rx_ready     = rx_rdy_q;
  assign bus.tx_full      = full_q;
  assign bus.tx_overflow  = ovf_q;
  assign bus.rx_overrun   = ovr_q;
  assign bus.rx_frame_err = ferr_q;
endmodule

// File: tb/tb_citadel_uart.sv
// tb/tb_citadel_uart.sv - scoreboard bench for citadel_uart (CLK_DIV=8, TXF_AW=4)
module tb_citadel_uart;
  localparam int CLK_DIV = 8;
  localparam int TXF_AW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rxd = 1'b1;
  logic uart_txd;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  citadel_uart_if bus();

  citadel_uart #(.CLK_DIV(CLK_DIV), .TXF_AW(TXF_AW)) dut (
    .r_clk(clk), .rst(rst), .bus(bus.slave), .uart_txd(uart_txd), .uart_rxd(uart_rxd)
  );

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  int   frame_starts[$];
  bit   mon_tx_on = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_total++;
    $display("FAIL %s: got %0h, expected nothing", name, act);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b);
    @(posedge clk); #1;
    bus.tx = b; bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    bus.tx_ready = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1;
    uart_rxd = 1'b0;
    repeat (CLK_DIV) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CLK_DIV) @(posedge clk); #1;
    end
    uart_rxd = stop_bit;
    repeat (CLK_DIV) @(posedge clk); #1;
    uart_rxd = 1'b1;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1; bus.clr_err = 1'b1;
    @(posedge clk); #1; bus.clr_err = 1'b0;
  endtask

  task automatic pulse_ack();
    @(posedge clk); #1; bus.rx_ack = 1'b1;
    @(posedge clk); #1; bus.rx_ack = 1'b0;
  endtask

  task automatic wait_tx_drain(input int budget);
    int t = 0;
    while (tx_exp.size() != 0 && t < budget) begin
      @(posedge clk); t++;
    end
    #1;
    if (tx_exp.size() != 0) fail_now("tx_drain_timeout", tx_exp.size());
  endtask

  // TX monitor: decode frames off uart_txd mid-bit and compare with the scoreboard
  initial begin
    logic [7:0] b;
    logic st;
    forever begin
      @(negedge clk);
      if (!rst && uart_txd === 1'b0) begin
        frame_starts.push_back(cyc);
        repeat (CLK_DIV / 2) @(negedge clk);
        st = uart_txd;
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          b[i] = uart_txd;
        end
        repeat (CLK_DIV) @(negedge clk);
        if (mon_tx_on) begin
          check("tx_start_bit", st, 1'b0);
          check("tx_stop_bit", uart_txd, 1'b1);
          if (tx_exp.size() == 0) fail_now("tx_unexpected_frame", b);
          else check("tx_byte", b, tx_exp.pop_front());
        end
      end
    end
  end

  // RX monitor: a delivery is rx_ready rising or rx changing while ready
  initial begin
    logic       prev_rdy = 1'b0;
    logic [7:0] prev_rx = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && bus.rx_ready === 1'b1 && (!prev_rdy || bus.rx !== prev_rx)) begin
        if (rx_exp.size() == 0) fail_now("rx_unexpected_byte", bus.rx);
        else check("rx_byte", bus.rx, rx_exp.pop_front());
      end
      prev_rdy = bus.rx_ready;
      prev_rx  = bus.rx;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    bit saw_low;
    int bad;
    bus.tx = 8'h00; bus.tx_ready = 1'b0; bus.rx_ack = 1'b0; bus.clr_err = 1'b0;

    // 1. reset state
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    tick(2);
    check("rst_txd", uart_txd, 1'b1);
    check("rst_rx", bus.rx, 8'h00);
    check("rst_rx_ready", bus.rx_ready, 1'b0);
    check("rst_tx_full", bus.tx_full, 1'b0);
    check("rst_tx_overflow", bus.tx_overflow, 1'b0);
    check("rst_rx_overrun", bus.rx_overrun, 1'b0);
    check("rst_rx_frame_err", bus.rx_frame_err, 1'b0);

    // 2. single byte, latency to start bit
    tx_exp.push_back(8'h55);
    strobe(8'h55);
    tick(1);
    check("tx_latency_edge_n1_high", uart_txd, 1'b1);
    tick(1);
    check("tx_latency_edge_n2_low", uart_txd, 1'b0);
    wait_tx_drain(200);
    tick(10);

    // 3. fill FIFO behind a busy frame, overflow, back-to-back frames
    frame_starts.delete();
    tx_exp.push_back(8'hF0);
    strobe(8'hF0);
    tick(3);
    for (int k = 0; k < 17; k++) begin
      @(posedge clk); #1;
      bus.tx = 8'(k); bus.tx_ready = 1'b1;
      if (k < 16) tx_exp.push_back(8'(k));
    end
    @(posedge clk); #1;
    bus.tx_ready = 1'b0;
    check("fifo_tx_full", bus.tx_full, 1'b1);
    check("fifo_tx_overflow", bus.tx_overflow, 1'b1);
    wait_tx_drain(2000);
    tick(10);
    check("tx_frame_count", frame_starts.size(), 17);
    bad = 0;
    for (int i = 1; i < frame_starts.size(); i++)
      if (frame_starts[i] - frame_starts[i-1] != 10 * CLK_DIV) bad++;
    check("tx_no_gap_frame_spacing_errors", bad, 0);
    check("fifo_drained_not_full", bus.tx_full, 1'b0);
    pulse_clr();
    check("clr_tx_overflow", bus.tx_overflow, 1'b0);

    // 4. receive A3, then ack
    rx_exp.push_back(8'hA3);
    send_rx(8'hA3, 1'b1);
    tick(4);
    check("rx_a3_ready", bus.rx_ready, 1'b1);
    check("rx_a3_value", bus.rx, 8'hA3);
    pulse_ack();
    check("rx_ack_clears_ready", bus.rx_ready, 1'b0);
    check("rx_ack_keeps_value", bus.rx, 8'hA3);

    // 5. overrun, clear, then ack coincident with delivery
    rx_exp.push_back(8'h11);
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    tick(4);
    check("overrun_rx_keeps_old", bus.rx, 8'h11);
    check("overrun_flag", bus.rx_overrun, 1'b1);
    pulse_clr();
    check("clr_rx_overrun", bus.rx_overrun, 1'b0);
    rx_exp.push_back(8'h22);
    saw_low = 1'b0;
    fork
      send_rx(8'h22, 1'b1);
      begin
        @(posedge clk);
        repeat (78) @(posedge clk); #1;
        bus.rx_ack = 1'b1;
        @(posedge clk); #1;
        bus.rx_ack = 1'b0;
      end
      begin
        repeat (84) begin
          @(negedge clk);
          if (!bus.rx_ready) saw_low = 1'b1;
        end
      end
    join
    tick(4);
    check("ack_at_delivery_value", bus.rx, 8'h22);
    check("ack_at_delivery_ready_never_dropped", saw_low, 1'b0);
    check("ack_at_delivery_no_overrun", bus.rx_overrun, 1'b0);
    pulse_ack();
    check("rx_ready_cleared_before_ferr", bus.rx_ready, 1'b0);

    // 6. framing error, then a short glitch
    send_rx(8'h5A, 1'b0);
    tick(20);
    check("frame_err_flag", bus.rx_frame_err, 1'b1);
    check("frame_err_no_ready", bus.rx_ready, 1'b0);
    pulse_clr();
    check("clr_frame_err", bus.rx_frame_err, 1'b0);
    @(posedge clk); #1;
    uart_rxd = 1'b0;
    tick(2);
    uart_rxd = 1'b1;
    tick(100);
    check("glitch_no_ready", bus.rx_ready, 1'b0);
    check("glitch_no_frame_err", bus.rx_frame_err, 1'b0);
    check("glitch_no_overrun", bus.rx_overrun, 1'b0);
    check("rx_scoreboard_empty", rx_exp.size(), 0);
    check("tx_scoreboard_empty", tx_exp.size(), 0);

    // 1b. reset asserted mid TX frame
    mon_tx_on = 1'b0;
    strobe(8'h00);
    tick(30);
    check("mid_frame_txd_low", uart_txd, 1'b0);
    rst = 1'b1;
    #1;
    check("async_reset_txd_high", uart_txd, 1'b1);
    check("async_reset_tx_full", bus.tx_full, 1'b0);
    tick(3);
    rst = 1'b0;
    tick(20);
    check("after_reset_txd_idle", uart_txd, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
